// File: rtl/dual_grant_sequencer_pkg.sv
// Shared defaults and state encoding for the dual grant sequencer and its index decoder.
package dual_grant_sequencer_pkg;

    localparam int unsigned N_REQ_DEF   = 12;
    localparam int unsigned IDX_W_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLOT1 = 2'd1,
        ST_GAP   = 2'd2,
        ST_SLOT2 = 2'd3
    } seq_state_e;

endpackage

// File: rtl/dual_grant_sequencer_idx_onehot_dec.sv
// Index to one-hot decoder with an in-range flag; out-of-range indices decode to all-zero.
module idx_onehot_dec
    import dual_grant_sequencer_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [N_REQ-1:0] o_onehot_c,
    output logic             o_in_range_c
);

    assign o_in_range_c = (32'(i_idx) < N_REQ);
    assign o_onehot_c   = o_in_range_c ? (N_REQ'(1) << i_idx) : '0;

endmodule

// File: rtl/dual_grant_sequencer.sv
// Converts an accepted (first, second) index pair into sequential one-hot grants,
// each slot ending on requester ack or timeout, with a one-cycle gap between slots.
module dual_grant_sequencer
    import dual_grant_sequencer_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W-1:0] second_idx,
    input  logic             second_en,
    input  logic             grant_ack,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             err_idx,
    output logic             timeout_p
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    seq_state_e       r_state;
    logic [IDX_W-1:0] r_second;
    logic             r_second_en;
    logic [CNT_W-1:0] r_cnt;
    logic [N_REQ-1:0] r_grant;
    logic             r_busy;
    logic             r_in_ready;
    logic             r_err_idx;
    logic             r_timeout_p;

    seq_state_e       w_state_nxt;
    logic [IDX_W-1:0] w_second_nxt;
    logic             w_second_en_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [N_REQ-1:0] w_grant_nxt;
    logic             w_err_nxt;
    logic             w_timeout_nxt;

    logic [IDX_W-1:0] w_idx_mux;
    logic [N_REQ-1:0] w_onehot;
    logic             w_in_range;
    logic             w_second_in_ok;
    logic             w_slot_end;

    // Single decoder: the incoming first index while idle, the latched second index otherwise.
    assign w_idx_mux = (r_state == ST_IDLE) ? first_idx : r_second;

    idx_onehot_dec #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_dec (
        .i_idx        (w_idx_mux),
        .o_onehot_c   (w_onehot),
        .o_in_range_c (w_in_range)
    );

    assign w_second_in_ok = (32'(second_idx) < N_REQ);
    assign w_slot_end     = grant_ack || (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_second_nxt    = r_second;
        w_second_en_nxt = r_second_en;
        w_cnt_nxt       = r_cnt;
        w_grant_nxt     = r_grant;
        w_err_nxt       = 1'b0;
        w_timeout_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_second_nxt    = second_idx;
                    w_second_en_nxt = second_en;
                    w_cnt_nxt       = '0;
                    if (w_in_range) begin
                        w_state_nxt = ST_SLOT1;
                        w_grant_nxt = w_onehot;
                    end else begin
                        // A bad first index still lets a good second index be serviced.
                        w_err_nxt   = 1'b1;
                        w_grant_nxt = '0;
                        if (second_en && w_second_in_ok) begin
                            w_state_nxt = ST_GAP;
                        end
                    end
                end
            end
            ST_SLOT1: begin
                if (w_slot_end) begin
                    w_timeout_nxt = !grant_ack;
                    w_grant_nxt   = '0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_IDLE;
                    if (r_second_en) begin
                        if (w_in_range) begin
                            w_state_nxt = ST_GAP;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_SLOT2;
                w_grant_nxt = w_onehot;
                w_cnt_nxt   = '0;
            end
            ST_SLOT2: begin
                if (w_slot_end) begin
                    w_timeout_nxt = !grant_ack;
                    w_grant_nxt   = '0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_second    <= '0;
            r_second_en <= 1'b0;
            r_cnt       <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_err_idx   <= 1'b0;
            r_timeout_p <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_second    <= w_second_nxt;
            r_second_en <= w_second_en_nxt;
            r_cnt       <= w_cnt_nxt;
            r_grant     <= w_grant_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_err_idx   <= w_err_nxt;
            r_timeout_p <= w_timeout_nxt;
        end
    end

    assign grant     = r_grant;
    assign busy      = r_busy;
    assign in_ready  = r_in_ready;
    assign err_idx   = r_err_idx;
    assign timeout_p = r_timeout_p;

endmodule

// File: tb/tb_dual_grant_sequencer.sv
// Bench for dual_grant_sequencer: directed scenarios plus random pairs checked cycle by cycle
// against a transaction-level plan of expected grants, pulses and handshake levels.
module tb_dual_grant_sequencer;

    localparam int unsigned NR  = 12;
    localparam int unsigned IW  = 4;
    localparam int unsigned TMO = 4;
    localparam int unsigned CW  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] first_idx;
    logic [IW-1:0] second_idx;
    logic          second_en;
    logic          grant_ack;
    logic [NR-1:0] grant;
    logic          busy;
    logic          err_idx;
    logic          timeout_p;

    always #5 clk = ~clk;

    dual_grant_sequencer #(
        .N_REQ   (NR),
        .IDX_W   (IW),
        .TIMEOUT (TMO),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .first_idx  (first_idx),
        .second_idx (second_idx),
        .second_en  (second_en),
        .grant_ack  (grant_ack),
        .grant      (grant),
        .busy       (busy),
        .err_idx    (err_idx),
        .timeout_p  (timeout_p)
    );

    typedef struct {
        logic [NR-1:0] g;
        logic          busy;
        logic          err;
        logic          tmo;
        logic          ack;
    } rec_t;

    rec_t exp_q[$];
    logic pend_err;
    logic pend_to;
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Expected outputs for one cycle; pending pulses land on the cycle after the edge that caused them.
    function automatic void push_rec(input logic [NR-1:0] g, input logic b, input logic a);
        rec_t r;
        r.g    = g;
        r.busy = b;
        r.err  = pend_err;
        r.tmo  = pend_to;
        r.ack  = a;
        pend_err = 1'b0;
        pend_to  = 1'b0;
        exp_q.push_back(r);
    endfunction

    // A slot lasts until the ack cycle d, or TMO cycles when d is out of reach.
    function automatic void plan_slot(input int idx, input int d);
        int len;
        len = (d < int'(TMO)) ? d + 1 : int'(TMO);
        for (int c = 0; c < len; c++) push_rec(NR'(1) << idx, 1'b1, c == d);
        pend_to = (d >= int'(TMO));
    endfunction

    function automatic void plan(input int f, input int s, input bit en, input int d1, input int d2);
        bit fv;
        bit sv;
        fv = f < int'(NR);
        sv = s < int'(NR);
        exp_q.delete();
        pend_err = 1'b0;
        pend_to  = 1'b0;
        if (fv) begin
            plan_slot(f, d1);
            if (en) begin
                if (sv) begin
                    push_rec('0, 1'b1, 1'($urandom));
                    plan_slot(s, d2);
                end else begin
                    pend_err = 1'b1;
                end
            end
        end else begin
            pend_err = 1'b1;
            if (en && sv) begin
                push_rec('0, 1'b1, 1'($urandom));
                plan_slot(s, d2);
            end
        end
        push_rec('0, 1'b0, 1'b0);
    endfunction

    task automatic check_rec(input rec_t r, input string tag);
        chk({tag, ".grant"},     32'(grant),     32'(r.g));
        chk({tag, ".busy"},      32'(busy),      32'(r.busy));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(!r.busy));
        chk({tag, ".err_idx"},   32'(err_idx),   32'(r.err));
        chk({tag, ".timeout_p"}, 32'(timeout_p), 32'(r.tmo));
    endtask

    // Called from inside an idle cycle; returns inside the first idle cycle after the pair.
    task automatic run_pair(input int f, input int s, input bit en, input int d1, input int d2,
                            input bit hold, input string tag);
        plan(f, s, en, d1, d2);
        @(negedge clk);
        in_valid   = 1'b1;
        first_idx  = IW'(f);
        second_idx = IW'(s);
        second_en  = en;
        grant_ack  = 1'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            check_rec(exp_q[i], tag);
            if (i < exp_q.size() - 1) begin
                @(negedge clk);
                grant_ack = exp_q[i].ack;
                if (!hold) begin
                    in_valid   = 1'($urandom);
                    first_idx  = IW'($urandom);
                    second_idx = IW'($urandom);
                    second_en  = 1'($urandom);
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        rec_t r;
        r.g = '0; r.busy = 1'b0; r.err = 1'b0; r.tmo = 1'b0; r.ack = 1'b0;
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            grant_ack = 1'($urandom);
            @(posedge clk);
            #1;
            check_rec(r, "idle");
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        first_idx  = '0;
        second_idx = '0;
        second_en  = 1'b0;
        grant_ack  = 1'b0;
        #7;
        chk("reset.grant",    32'(grant),     32'h0);
        chk("reset.busy",     32'(busy),      32'h0);
        chk("reset.in_ready", 32'(in_ready),  32'h1);
        chk("reset.err_idx",  32'(err_idx),   32'h0);
        chk("reset.timeout",  32'(timeout_p), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(1);

        run_pair(11, 3, 1'b1, 1, 1, 1'b0, "t1_two_slots");
        run_pair(5, 0, 1'b0, 0, 0, 1'b0, "t2_single_ack0");
        run_pair(7, 0, 1'b0, 99, 0, 1'b0, "t3_timeout");
        run_pair(13, 2, 1'b1, 0, 1, 1'b0, "t4_bad_first");
        run_pair(4, 14, 1'b1, 1, 0, 1'b0, "t4_bad_second");
        run_pair(15, 12, 1'b1, 0, 0, 1'b0, "t4_both_bad");
        run_pair(6, 6, 1'b1, 1, 1, 1'b1, "t5_same_idx_hold");
        run_pair(0, 11, 1'b1, 3, 99, 1'b0, "t_edge_ack_last");

        // Reset asserted in the middle of the second slot.
        @(negedge clk);
        in_valid = 1'b1; first_idx = 4'd2; second_idx = 4'd9; second_en = 1'b1; grant_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("t6.slot1", 32'(grant), 32'h004);
        @(negedge clk);
        in_valid = 1'b0; grant_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("t6.gap", 32'(grant), 32'h000);
        @(negedge clk);
        grant_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("t6.slot2", 32'(grant), 32'h200);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t6.rst_grant",    32'(grant),    32'h0);
        chk("t6.rst_in_ready", 32'(in_ready), 32'h1);
        chk("t6.rst_busy",     32'(busy),     32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(1);
        run_pair(9, 1, 1'b1, 2, 0, 1'b0, "t6_after_reset");

        for (int k = 0; k < 200; k++) begin
            run_pair(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                     ($urandom_range(0, 3) == 0), "rand");
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 2)));
        end

        @(negedge clk);
        in_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
